sar_search: RTL

//  Successive-approximation search engine: drives a probe value into an external combinational

---
 rtl/sar_pkg.sv | 23 ++
 rtl/sar_search.sv | 124 ++++++++++++
 2 files changed

// File: rtl/sar_pkg.sv
// Shared types and constants for the successive-approximation search engine.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sar_pkg;

  // Search control states; WAIT is only entered when the comparator path is registered.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMP  = 2'd1,
    WAIT = 2'd2
  } state_t;

  // Bit positions inside the comparator code {gt, lt, eq}.
  localparam int CMP_GT = 2;
  localparam int CMP_LT = 1;
  localparam int CMP_EQ = 0;

  // The only legal (one-hot) comparator codes.
  localparam logic [2:0] CODE_GT = 3'(1 << CMP_GT);
  localparam logic [2:0] CODE_LT = 3'(1 << CMP_LT);
  localparam logic [2:0] CODE_EQ = 3'(1 << CMP_EQ);

endpackage

// File: rtl/sar_search.sv
// Binary search of an unknown target through an external {gt,lt,eq} magnitude comparator.
// Latency: start->done = comparisons+1 cycles (2*comparisons+1 with CMP_PIPE_EN defined).
// Backpressure: none; start is ignored while busy and accepted again in the done cycle.
module sar_search
  import sar_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       cmp_y,
  output logic [WIDTH-1:0] probe,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             err
);

  localparam logic [WIDTH:0]   HI_INIT   = {1'b0, {WIDTH{1'b1}}};
  localparam logic [WIDTH:0]   LO_INIT   = '0;
  localparam logic [WIDTH-1:0] PROBE_MAX = {WIDTH{1'b1}};
  localparam logic [WIDTH:0]   ONE       = (WIDTH+1)'(1);

  // With a registered comparator path every new probe needs one settling cycle before it is sampled.
`ifdef CMP_PIPE_EN
  localparam state_t AFTER_PROBE = WAIT;
`else
  localparam state_t AFTER_PROBE = CMP;
`endif

  // Midpoint of the live interval; operands are one bit wider so the sum never wraps.
  function automatic logic [WIDTH-1:0] midpoint(input logic [WIDTH:0] a, input logic [WIDTH:0] b);
    return WIDTH'((a + b) >> 1);
  endfunction

  state_t         state;
  logic [WIDTH:0] lo;
  logic [WIDTH:0] hi;
  logic [WIDTH:0] lo_gt;
  logic [WIDTH:0] hi_lt;

  // Candidate interval bounds if the comparator answers gt / lt for the current probe.
  assign lo_gt = {1'b0, probe} + ONE;
  assign hi_lt = {1'b0, probe} - ONE;

  // Search FSM: narrows [lo,hi] by one comparator answer per CMP cycle, aborting on bad answers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      lo     <= LO_INIT;
      hi     <= HI_INIT;
      probe  <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      err    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            lo    <= LO_INIT;
            hi    <= HI_INIT;
            probe <= midpoint(LO_INIT, HI_INIT);
            err   <= 1'b0;
            busy  <= 1'b1;
            state <= AFTER_PROBE;
          end
        end
        WAIT: begin
          state <= CMP;
        end
        CMP: begin
          case (cmp_y)
            CODE_GT: begin
              // gt at the top code or an emptied interval means the answers are inconsistent.
              if (probe == PROBE_MAX || lo_gt > hi) begin
                err   <= 1'b1;
                done  <= 1'b1;
                busy  <= 1'b0;
                state <= IDLE;
              end else begin
                lo    <= lo_gt;
                probe <= midpoint(lo_gt, hi);
                state <= AFTER_PROBE;
              end
            end
            CODE_LT: begin
              // lt at zero would underflow hi; checked before the interval test.
              if (probe == '0 || lo > hi_lt) begin
                err   <= 1'b1;
                done  <= 1'b1;
                busy  <= 1'b0;
                state <= IDLE;
              end else begin
                hi    <= hi_lt;
                probe <= midpoint(lo, hi_lt);
                state <= AFTER_PROBE;
              end
            end
            CODE_EQ: begin
              result <= probe;
              done   <= 1'b1;
              busy   <= 1'b0;
              state  <= IDLE;
            end
            default: begin
              err   <= 1'b1;
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= IDLE;
            end
          endcase
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
